// File: rtl/esc_data_memory8_pkg.sv
// Shared types and constants for the vector-store pixel memory.
// Lane geometry, the store vector type and the store FSM encoding live here.
package esc_data_memory8_pkg;

    localparam int LANES_USED  = 8;
    localparam int LANES_TOTAL = 16;
    localparam int LANE_W      = 16;
    localparam int ADDR_W      = 16;

    typedef logic [LANES_TOTAL-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Lane addresses wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [2:0]        lane);
        return base + {{(ADDR_W-3){1'b0}}, lane};
    endfunction

endpackage

// File: rtl/esc_data_memory8_if.sv
// Store/readback bus of the pixel memory.
// Handshake: a store transfers on a rising edge where we=1 and ready=1; we while ready=0 is dropped, not held.
interface esc_data_memory8_if #(
    parameter int PIX_SIZE = 8
);
    import esc_data_memory8_pkg::*;

    logic                  we;
    logic [ADDR_W-1:0]     addr;
    vec_t                  wd;
    logic [LANES_USED-1:0] wmask;
    logic                  ready;
    logic                  done;
    logic [ADDR_W-1:0]     raddr;
    logic [PIX_SIZE-1:0]   rd;

    modport master (
        output we, addr, wd, wmask, raddr,
        input  ready, done, rd
    );

    modport slave (
        input  we, addr, wd, wmask, raddr,
        output ready, done, rd
    );

endinterface

// File: rtl/esc_data_memory8_pixel_ram.sv
// Pixel storage: one synchronous write port, asynchronous read.
// Reads beyond DEPTH return zero; the writer is responsible for range-gating writes.
module pixel_ram #(
    parameter int DEPTH  = 9216,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_in_range;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rd_in_range = ({1'b0, raddr} < DEPTH_L);
    assign rdata       = rd_in_range ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/esc_data_memory8.sv
// Vector-store pixel memory: one accepted 8-lane store is serialised into one pixel write per cycle,
// followed by a single DONE cycle that may accept the next store.
module esc_data_memory8
    import esc_data_memory8_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int PIX_SIZE     = 8
) (
    input  logic                clk,
    input  logic                rst,
    esc_data_memory8_if.slave   bus,
    output state_t              dbg_state
);

    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t                            state_q, state_d;
    logic [2:0]                        lane_q;
    logic [ADDR_W-1:0]                 addr_q;
    logic [LANES_USED-1:0][PIX_SIZE-1:0] pix_q;
    logic [LANES_USED-1:0]             mask_q;

    logic                accept;
    logic                ready;
    logic                done;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIX_SIZE-1:0] wr_data;
    logic [PIX_SIZE-1:0] rd_pix;
    logic                unused_wd_bits;

    assign accept = bus.we && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_WRITE;
            ST_WRITE: if (lane_q == 3'd7) state_d = ST_DONE;
            ST_DONE:  state_d = accept ? ST_WRITE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q != ST_WRITE);
        done  = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 3'd0;
        end else if (accept) begin
            lane_q <= 3'd0;
        end else if (state_q == ST_WRITE) begin
            lane_q <= lane_q + 3'd1;
        end
    end

    // Only the stored pixel bits of lanes 0-7 are captured; the rest of the vector is dropped here.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus.addr;
            mask_q <= bus.wmask;
            for (int k = 0; k < LANES_USED; k++) begin
                pix_q[k] <= bus.wd[k][PIX_SIZE-1:0];
            end
        end
    end

    // Masked or out-of-range lanes still spend their cycle; rst cancels the pending lane write.
    always_comb begin
        wr_addr = lane_addr(addr_q, lane_q);
        wr_data = pix_q[lane_q];
        wr_en   = (state_q == ST_WRITE) && mask_q[lane_q] &&
                  ({1'b0, wr_addr} < DEPTH_L) && !rst;
    end

    pixel_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (PIX_SIZE),
        .ADDR_W (ADDR_W)
    ) u_pixel_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (bus.raddr),
        .rdata (rd_pix)
    );

    assign unused_wd_bits = ^bus.wd;

    assign bus.ready = ready;
    assign bus.done  = done;
    assign bus.rd    = rd_pix;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_esc_data_memory8.sv
// Bench for esc_data_memory8: randomized vector stores against an array model of the pixel memory,
// with a done-timing scoreboard fed at accept time and drained by a monitor on each done pulse.
module tb_esc_data_memory8;
    import esc_data_memory8_pkg::*;

    localparam int IW    = 96;
    localparam int IH    = 96;
    localparam int PS    = 8;
    localparam int DEPTH = IW * IH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    state_t      dbg_state;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0]   exp_q[$];
    logic [PS-1:0] model_mem [65536];
    bit            known [65536];
    int            pend[$];

    esc_data_memory8_if #(.PIX_SIZE(PS)) bus_if();

    esc_data_memory8 #(
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .PIX_SIZE     (PS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < LANES_TOTAL; k++) v[k] = 16'($urandom);
        return v;
    endfunction

    // Reference model: lane k lands at (base+k) mod 2^16 if enabled and inside the image.
    task automatic model_apply(input logic [15:0] a, input vec_t wd, input logic [7:0] m, input int nl);
        for (int k = 0; k < nl; k++) begin
            int addr_k;
            addr_k = (int'(a) + k) % 65536;
            if (m[k] && addr_k < DEPTH) begin
                model_mem[addr_k] = wd[k][PS-1:0];
                known[addr_k]     = 1'b1;
            end
        end
    endtask

    // driver: call at a negedge while the DUT should be ready
    task automatic store(input logic [15:0] a, input vec_t wd, input logic [7:0] m, input bit commit);
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wd    = wd;
        bus_if.wmask = m;
        check("ready_before_accept", bus_if.ready, 1);
        @(posedge clk);
        #1;
        exp_q.push_back(cyc + 8);
        bus_if.we    = 1'b0;
        bus_if.addr  = 16'($urandom);
        bus_if.wd    = rand_vec();
        bus_if.wmask = 8'($urandom);
        if (commit) model_apply(a, wd, m, 8);
        for (int k = 0; k < 8; k++) pend.push_back((int'(a) + k) % 65536);
    endtask

    // Eight busy cycles, then the DONE cycle; optionally pokes an extra store at busy cycle 'poke'.
    task automatic wait_end(input int poke);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == poke) begin
                bus_if.we    = 1'b1;
                bus_if.addr  = 16'h0200;
                bus_if.wd    = rand_vec();
                bus_if.wmask = 8'hFF;
            end else begin
                bus_if.we = 1'b0;
            end
            check("ready_busy", bus_if.ready, 0);
        end
        @(negedge clk);
        bus_if.we = 1'b0;
        check("ready_in_done", bus_if.ready, 1);
    endtask

    task automatic read_check(input int a);
        @(negedge clk);
        bus_if.raddr = 16'(a);
        #1;
        if (a >= DEPTH) check($sformatf("rd_oob[0x%0h]", a), bus_if.rd, 0);
        else if (known[a]) check($sformatf("rd[0x%0h]", a), bus_if.rd, model_mem[a]);
    endtask

    task automatic read_pending();
        while (pend.size() > 0) read_check(pend.pop_front());
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e);
            end
        end
    end

    initial begin
        #2_000_000;
        n_vec++;
        n_err++;
        $display("FAIL timeout: bench did not complete, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        vec_t        v;
        logic [15:0] a;
        logic [7:0]  m;
        int          sel;

        bus_if.we    = 1'b0;
        bus_if.addr  = '0;
        bus_if.wd    = '0;
        bus_if.wmask = '0;
        bus_if.raddr = '0;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bus_if.ready, 1);
        check("reset_done", bus_if.done, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        // basic full store at 0
        v = rand_vec();
        for (int k = 0; k < 8; k++) v[k] = 16'h0010 + 16'(k);
        store(16'h0000, v, 8'hFF, 1'b1);
        wait_end(-1);
        read_pending();

        // preload regions back-to-back
        store(16'h0100, rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        store(16'h0200, rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        store(16'h0300, rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        store(16'(DEPTH - 8), rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        read_pending();

        // single-lane mask with upper bits to discard
        v = rand_vec();
        v[0] = 16'hABCD;
        store(16'h0100, v, 8'h01, 1'b1);
        wait_end(-1);
        read_pending();

        // store attempt during WRITE is dropped; store in DONE goes straight through
        store(16'h0400, rand_vec(), 8'hFF, 1'b1);
        wait_end(3);
        store(16'h0500, rand_vec(), 8'hFF, 1'b1);
        wait_end(7);
        read_pending();
        for (int i = 0; i < 8; i++) read_check(16'h0200 + i);

        // store straddling the end of the image
        store(16'(DEPTH - 3), rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        read_pending();
        for (int i = DEPTH - 8; i <= DEPTH; i++) read_check(i);
        read_check(65535);

        // reset at the 4th edge after accept: only lanes 0-2 land
        v = rand_vec();
        store(16'h0300, v, 8'hFF, 1'b0);
        model_apply(16'h0300, v, 8'hFF, 3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_ready", bus_if.ready, 1);
        check("abort_done", bus_if.done, 0);
        check("abort_state", dbg_state, ST_IDLE);
        pend.delete();
        for (int i = 0; i < 8; i++) read_check(16'h0300 + i);
        for (int i = 0; i < 8; i++) read_check(i);

        // address wrap past 0xFFFF
        @(negedge clk);
        store(16'hFFFE, rand_vec(), 8'hFF, 1'b1);
        wait_end(-1);
        read_pending();
        for (int i = 0; i < 8; i++) read_check(i);

        // randomized stores, mixing back-to-back and idle gaps
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      a = 16'($urandom_range(0, DEPTH - 1));
            else if (sel == 1) a = 16'($urandom_range(DEPTH - 8, DEPTH + 4));
            else               a = 16'($urandom_range(65530, 65535));
            m = 8'($urandom);
            store(a, rand_vec(), m, 1'b1);
            wait_end($urandom_range(0, 11));
            if ($urandom_range(0, 1) == 0 || n == 23) begin
                read_pending();
                @(negedge clk);
            end
        end

        @(negedge clk);
        check("done_pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
